fifo_read_control: RTL
======================

# fifo_read_control

Read-domain controller for the dual-clock FIFO. It consumes the write pointer after it has been synchronized into `clock_read`, maintains the read pointer in binary and Gray form, and generates the empty, almost-empty and level status. It drives the synchronous-read memory port and presents the data to the consumer through a 2-entry show-ahead valid/ready output buffer. Its Gray `read_pointer` is the value the write domain synchronizes back for its full logic.

## Interface
- ADDR_WIDTH, 6, memory address width; pointers are ADDR_WIDTH+1 bits (7 by default; depth 64).
- DATA_WIDTH, 8, word width.
- ALMOST_EMPTY_LEVEL, 4, almost_empty asserts when read_level <= this value.

- clock_read  input  1  read-domain clock; all logic is on its rising edge.
- read_reset_n  input  1  reset, asynchronous, active-low.
- sync_write_pointer  input  ADDR_WIDTH+1  Gray write pointer, already 2-flop synchronized to clock_read.
- read_pointer  output  ADDR_WIDTH+1  Gray read pointer (registered), exported to the write domain.
- read_address  output  ADDR_WIDTH  memory read address = low ADDR_WIDTH bits of the binary read pointer.
- read_enable_mem  output  1  memory read strobe (combinational).
- mem_read_data  input  DATA_WIDTH  memory output; valid the cycle after read_enable_mem.
- rd_data  output  DATA_WIDTH  head word of the output buffer.
- rd_valid  output  1  output buffer is non-empty.
- rd_ready  input  1  consumer accepts rd_data; a pop occurs when rd_valid && rd_ready.
- empty  output  1  no unread words remain in memory (registered).
- almost_empty  output  1  registered; read_level <= ALMOST_EMPTY_LEVEL.
- read_level  output  ADDR_WIDTH+1  registered count of words in memory not yet issued.

## Operation
- State: `rbin` (binary pointer), `read_pointer` (Gray), `mem_pending` (1 bit), `buf_count` (0..2), head register and skid register, `empty`, `almost_empty`, `read_level`.
- Issue condition: `read_enable_mem = !empty && (mem_pending + buf_count - pop) < 2`. This keeps at most 2 words between the memory and the consumer.
- On issue:
  - `read_address = rbin[ADDR_WIDTH-1:0]`.
  - `rbin` increments modulo 2^(ADDR_WIDTH+1); 127 wraps to 0.
  - `read_pointer <= rbin_next ^ (rbin_next >> 1)`.
- `mem_pending <= read_enable_mem` each cycle.
- When `mem_pending` is high, mem_read_data is written into the buffer:
  - into the head if the buffer is empty, or if it holds 1 word that is popped this cycle;
  - otherwise into the skid register.
- On a pop, the skid word, if present, moves to the head.
- Word order is strictly preserved.
- `empty <= (gray(rbin_next) == sync_write_pointer)`.
- `read_level <= gray2bin(sync_write_pointer) - rbin_next`, modulo 2^(ADDR_WIDTH+1).
- `almost_empty <= (that level <= ALMOST_EMPTY_LEVEL)`.
- `rd_valid = (buf_count != 0)`.
- rd_ready while rd_valid is low has no effect.
- A simultaneous pop and memory return with buf_count = 1 leaves buf_count = 1, holding the new word.
- The state buf_count = 2 with mem_pending = 1 is unreachable; the bench asserts this.

## Timing
- Reset values:
  - read_pointer = 0, read_address = 0, read_enable_mem = 0;
  - empty = 1, almost_empty = 1, read_level = 0;
  - rd_valid = 0, rd_data = 0;
  - mem_pending = 0, buf_count = 0.
- Reset is asynchronous and may occur mid-operation. It clears all state and discards the in-flight and buffered words. The system resets the write side in the same event.
- Write-pointer arrival:
  - sync_write_pointer changes in cycle C;
  - empty and read_level update at the end of C;
  - the read is issued in C+1;
  - data is captured at the end of C+2;
  - rd_valid is high in C+3.
- Once streaming, with rd_ready held high and the FIFO non-empty, 1 word per cycle is delivered.
- The empty, almost_empty and read_level flags lag the pointers by one register stage. empty is pessimistic, never optimistic.

## Test plan
- Reset, then sync_write_pointer = 0 -> empty = 1, almost_empty = 1, rd_valid = 0, read_enable_mem never asserts.
- Step sync_write_pointer from Gray 0 to Gray 3 (0000010), with memory words A0..A2 and rd_ready = 1 -> rd_valid high 3 cycles after the step; A0, A1, A2 delivered on consecutive cycles; empty returns to 1; read_pointer = Gray 3.
- Fill 10 words with rd_ready = 0 -> read_enable_mem pulses exactly twice; buf_count = 2; read_level = 8; almost_empty = 0. Then rd_ready = 1 -> all 10 words delivered in order with no gaps after the first.
- Wrap: preset 120 writes already consumed, then stream 16 words -> read_pointer passes binary 127 to 0 with a correct Gray encoding; no duplicated or lost word; read_address wraps 63 to 0.
- Random rd_ready (50%) over 500 words -> in-order, lossless delivery; mem_pending + buf_count <= 2 at all times.
- Assert read_reset_n mid-stream with buf_count = 2 -> all outputs return to their reset values immediately (asynchronously); the next word delivered after reset release is memory[0].

Source files
------------

// File: rtl/fifo_read_control.sv
// Read-domain side of the dual-clock FIFO: read pointer (binary + Gray), empty/level
// status, synchronous-read memory issue and a 2-entry show-ahead output buffer.
module fifo_read_control #(
    parameter int ADDR_WIDTH         = 6,
    parameter int DATA_WIDTH         = 8,
    parameter int ALMOST_EMPTY_LEVEL = 4
) (
    input  logic                  clock_read,
    input  logic                  read_reset_n,
    input  logic [ADDR_WIDTH:0]   sync_write_pointer,
    output logic [ADDR_WIDTH:0]   read_pointer,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic                  read_enable_mem,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   read_level
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY_LEVEL);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]         rbin;
    logic [PW-1:0]         rbin_next;
    logic [PW-1:0]         level_next;
    logic                  mem_pending;
    logic [1:0]            buf_count;
    logic [1:0]            buf_count_next;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] skid;
    logic                  pop;
    logic                  head_load_mem;
    logic                  head_load_skid;
    logic                  skid_load;

    assign read_address = rbin[ADDR_WIDTH-1:0];
    assign rd_valid     = (buf_count != 2'd0);
    assign rd_data      = head;

    // Words already in flight or buffered, after this cycle's pop, bound the next issue.
    always_comb begin
        pop             = rd_valid && rd_ready;
        occupancy       = {2'b00, mem_pending} + {1'b0, buf_count} - {2'b00, pop};
        read_enable_mem = !empty && (occupancy < 3'd2);
        rbin_next       = rbin + {{ADDR_WIDTH{1'b0}}, read_enable_mem};
        level_next      = gray2bin(sync_write_pointer) - rbin_next;
    end

    always_comb begin
        head_load_mem  = mem_pending && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));
        head_load_skid = pop && (buf_count == 2'd2);
        skid_load      = mem_pending && (((buf_count == 2'd1) && !pop) || ((buf_count == 2'd2) && pop));
        buf_count_next = buf_count;
        if (head_load_mem) begin
            buf_count_next = 2'd1;
        end else if (skid_load && (buf_count == 2'd1)) begin
            buf_count_next = 2'd2;
        end else if (pop && !mem_pending) begin
            buf_count_next = buf_count - 2'd1;
        end
    end

    always_ff @(posedge clock_read or negedge read_reset_n) begin
        if (!read_reset_n) begin
            rbin         <= '0;
            read_pointer <= '0;
            mem_pending  <= 1'b0;
            buf_count    <= 2'd0;
            head         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            read_level   <= '0;
        end else begin
            rbin         <= rbin_next;
            read_pointer <= bin2gray(rbin_next);
            mem_pending  <= read_enable_mem;
            buf_count    <= buf_count_next;
            if (head_load_mem) begin
                head <= mem_read_data;
            end else if (head_load_skid) begin
                head <= skid;
            end
            // Status lags the pointers by one stage, so empty can only be pessimistic.
            empty        <= (bin2gray(rbin_next) == sync_write_pointer);
            almost_empty <= (level_next <= AE_LEVEL);
            read_level   <= level_next;
        end
    end

    // The skid word is only ever read while buf_count says it is valid.
    always_ff @(posedge clock_read) begin
        if (skid_load) begin
            skid <= mem_read_data;
        end
    end

endmodule
